// File: rtl/pixel_write_buffer.sv
// Clipping, optionally de-duplicating pixel FIFO feeding the vga_adapter write port.
// Optional feature: define PIXEL_DEDUP_EN to drop consecutive identical pushes.
module pixel_write_buffer #(
    parameter int DEPTH = 16,
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        in_plot,
    input  logic [7:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [2:0]  in_colour,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        out_plot,
    output logic [7:0]  out_x,
    output logic [6:0]  out_y,
    output logic [2:0]  out_colour,
    output logic [15:0] clip_count,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [8:0]  XLIM     = 9'(X_MAX);
    localparam logic [7:0]  YLIM     = 8'(Y_MAX);

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t        state_q, state_d;
    logic [17:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   clip_q, clip_d;
    logic          ovf_q, ovf_d;
    logic [17:0]   out_q, out_d;
    logic [17:0]   in_pix;
    logic          offscreen, full, empty, cand, push, pop;

    assign in_pix    = {in_x, in_y, in_colour};
    assign offscreen = ({1'b0, in_x} >= XLIM) || ({1'b0, in_y} >= YLIM);
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    // Clip is judged before fullness, so off-screen pixels never raise overflow.
    assign cand      = in_plot && !offscreen && !full;
    assign pop       = !empty && out_ready;

`ifdef PIXEL_DEDUP_EN
    logic [17:0] last_q;
    logic        last_vld_q;

    assign push = cand && !(last_vld_q && (last_q == in_pix));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (push) begin
            last_q     <= in_pix;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign push = cand;
`endif

    always_comb begin
        state_d  = IDLE;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        clip_d   = clip_q;
        ovf_d    = ovf_q;
        out_d    = out_q;
        case (state_q)
            IDLE:    state_d = pop ? EMIT : IDLE;
            EMIT:    state_d = pop ? EMIT : IDLE;
            default: state_d = IDLE;
        endcase
        if (in_plot && offscreen)
            clip_d = sat_inc(clip_q);
        if (in_plot && !offscreen && full)
            ovf_d = 1'b1;
        if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            out_d    = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            clip_q   <= '0;
            ovf_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            clip_q   <= clip_d;
            ovf_q    <= ovf_d;
            out_q    <= out_d;
        end
    end

    // Storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge CLOCK_50) begin
        if (push)
            mem_q[wr_ptr_q] <= in_pix;
    end

    assign in_ready   = !full;
    assign out_plot   = (state_q == EMIT);
    assign out_x      = out_q[17:10];
    assign out_y      = out_q[9:3];
    assign out_colour = out_q[2:0];
    assign clip_count = clip_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed bench for pixel_write_buffer: latency, clipping, overflow, dedup, backpressure, reset.
module tb_pixel_write_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_plot;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_ready;
    logic        out_ready;
    logic        out_plot;
    logic [7:0]  out_x;
    logic [6:0]  out_y;
    logic [2:0]  out_colour;
    logic [15:0] clip_count;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int bad_rdy = 0;
    logic rdy_last = 1'b0;
    logic [17:0] got_q[$];
    int          cyc_q[$];

    pixel_write_buffer #(.DEPTH(16), .X_MAX(160), .Y_MAX(120)) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .in_plot    (in_plot),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_plot   (out_plot),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_colour (out_colour),
        .clip_count (clip_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rdy_last <= out_ready;
    end

    always @(negedge clk) begin
        if (out_plot) begin
            got_q.push_back({out_x, out_y, out_colour});
            cyc_q.push_back(cyc);
            if (!rdy_last) bad_rdy++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_px(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        in_plot   = 1'b1;
        in_x      = x;
        in_y      = y;
        in_colour = c;
        @(posedge clk);
        #1;
        in_plot = 1'b0;
    endtask

    task automatic clear_log();
        got_q.delete();
        cyc_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_n;
        logic [7:0] ix;
        logic [6:0] iy;
        logic [2:0] ic;
        reset = 1'b1; in_plot = 1'b0; in_x = '0; in_y = '0; in_colour = '0; out_ready = 1'b0;
        idle(2);
        reset = 1'b0;
        check("rst_plot", 32'(out_plot), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_clip", 32'(clip_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_xyc", {14'd0, out_x, out_y, out_colour}, 0);

        // Basic latency
        out_ready = 1'b1;
        in_plot = 1'b1; in_x = 8'd10; in_y = 7'd20; in_colour = 3'b101;
        @(posedge clk); #1;
        in_plot = 1'b0;
        check("lat_n_plot", 32'(out_plot), 0);
        @(posedge clk); #1;
        check("lat_n1_plot", 32'(out_plot), 1);
        check("lat_n1_xyc", {14'd0, out_x, out_y, out_colour}, {14'd0, 8'd10, 7'd20, 3'd5});
        @(posedge clk); #1;
        check("lat_n2_plot", 32'(out_plot), 0);
        check("lat_hold_x", 32'(out_x), 10);
        clear_log();

        // Clipping, including wrapped x and the last legal pixel
        push_px(8'd246, 7'd60, 3'd1);
        push_px(8'd40, 7'd120, 3'd2);
        push_px(8'd159, 7'd119, 3'd3);
        idle(5);
        check("clip_count", 32'(clip_count), 2);
        check("clip_n", 32'(got_q.size()), 1);
        if (got_q.size() > 0) check("clip_px", 32'(got_q[0]), {14'd0, 8'd159, 7'd119, 3'd3});

        // Overflow and clip priority at full
        out_ready = 1'b0;
        clear_log();
        for (int i = 0; i < 16; i++) begin
            ix = 8'(i + 30); iy = 7'(i + 1); ic = 3'(i);
            push_px(ix, iy, ic);
            if (i == 14) check("ovf_ready15", 32'(in_ready), 1);
            if (i == 15) check("ovf_ready16", 32'(in_ready), 0);
        end
        push_px(8'd200, 7'd5, 3'd1);
        check("full_clip", 32'(clip_count), 3);
        check("full_clip_ovf", 32'(overflow), 0);
        push_px(8'd100, 7'd100, 3'd7);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_stall", 32'(got_q.size()), 0);
        out_ready = 1'b1;
        idle(20);
        check("ovf_n", 32'(got_q.size()), 16);
        if (got_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                ix = 8'(i + 30); iy = 7'(i + 1); ic = 3'(i);
                check("ovf_order", 32'(got_q[i]), {14'd0, ix, iy, ic});
            end
            check("ovf_consec", 32'(cyc_q[15] - cyc_q[0]), 15);
        end
        check("ovf_sticky", 32'(overflow), 1);
        check("ovf_drained", 32'(in_ready), 1);

        // Dedup
        clear_log();
        push_px(8'd5, 7'd5, 3'd1);
        push_px(8'd5, 7'd5, 3'd1);
        push_px(8'd5, 7'd5, 3'd1);
        push_px(8'd5, 7'd5, 3'd2);
        idle(6);
`ifdef PIXEL_DEDUP_EN
        exp_n = 2;
`else
        exp_n = 4;
`endif
        check("dedup_n", 32'(got_q.size()), 32'(exp_n));
        if (got_q.size() > 0) check("dedup_last", 32'(got_q[got_q.size() - 1]), {14'd0, 8'd5, 7'd5, 3'd2});
        check("dedup_clip", 32'(clip_count), 3);

        // Backpressure with out_ready toggling
        clear_log();
        bad_rdy = 0;
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2 == 0);
            ix = 8'(i + 60); iy = 7'(i + 2); ic = 3'(i);
            push_px(ix, iy, ic);
        end
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b0; idle(1);
            out_ready = 1'b1; idle(1);
        end
        out_ready = 1'b1;
        idle(10);
        check("bp_n", 32'(got_q.size()), 8);
        check("bp_ready_only", 32'(bad_rdy), 0);
        if (got_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                ix = 8'(i + 60); iy = 7'(i + 2); ic = 3'(i);
                check("bp_order", 32'(got_q[i]), {14'd0, ix, iy, ic});
            end
        end

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ix = 8'(i + 80);
            push_px(ix, 7'd9, 3'd4);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("mid_plot_before", 32'(out_plot), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_plot_async", 32'(out_plot), 0);
        check("mid_ready_async", 32'(in_ready), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_log();
        idle(6);
        check("post_rst_n", 32'(got_q.size()), 0);
        check("post_rst_ready", 32'(in_ready), 1);
        check("post_rst_clip", 32'(clip_count), 0);
        check("post_rst_ovf", 32'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
